// File: rtl/data_memory_pkg.sv
// rtl/data_memory_pkg.sv - shared encodings (ALU control, memory access size) and access helpers
//
// Purpose : single home for the encodings shared by the datapath: ALU control
//           codes and the MemSize access-size codes, plus small pure helpers
//           for alignment checking and store lane selection.
// Ports   : none (package).

package data_memory_pkg;

    // ALU control encodings used by the execute stage.
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    // MemSize encodings.
    localparam logic [1:0] SIZE_BYTE    = 2'b00;
    localparam logic [1:0] SIZE_HALF    = 2'b01;
    localparam logic [1:0] SIZE_WORD    = 2'b10;
    localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

    // True when the size code is illegal or the address is not naturally
    // aligned for that size. Byte accesses are always aligned.
    function automatic logic access_misaligned(input logic [1:0] size,
                                               input logic [1:0] byte_offset);
        logic bad;
        bad = 1'b0;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = byte_offset[0];
            SIZE_WORD: bad = (byte_offset != 2'b00);
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Byte-lane enables for a store, little-endian lane numbering.
    function automatic logic [3:0] store_lanes(input logic [1:0] size,
                                               input logic [1:0] byte_offset);
        logic [3:0] lanes;
        lanes = 4'b0000;
        case (size)
            SIZE_BYTE: lanes = 4'b0001 << byte_offset;
            SIZE_HALF: lanes = byte_offset[1] ? 4'b1100 : 4'b0011;
            SIZE_WORD: lanes = 4'b1111;
            default:   lanes = 4'b0000;
        endcase
        return lanes;
    endfunction

    // Replicate the low bits of the store data across all lanes so that the
    // lane mask alone decides which bytes are written.
    function automatic logic [31:0] store_replicate(input logic [1:0]  size,
                                                    input logic [31:0] data);
        logic [31:0] rep;
        rep = data;
        case (size)
            SIZE_BYTE: rep = {4{data[7:0]}};
            SIZE_HALF: rep = {2{data[15:0]}};
            default:   rep = data;
        endcase
        return rep;
    endfunction

endpackage

// File: rtl/data_memory_load_align.sv
// rtl/data_memory_load_align.sv - load lane selection and sign/zero extension
//
// Purpose : picks the addressed byte/halfword out of a 32-bit memory word and
//           extends it to 32 bits. Purely combinational.
// Ports   : word        - full memory word read from the array
//           byte_offset - Address[1:0] of the access
//           MemSize     - access size code
//           MemSigned   - 1 sign-extends byte/halfword, 0 zero-extends
//           value       - aligned, extended load value (0 for illegal size)

module load_align
    import data_memory_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  byte_offset,
    input  logic [1:0]  MemSize,
    input  logic        MemSigned,
    output logic [31:0] value
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        sel_byte = word[7:0];
        case (byte_offset)
            2'd0: sel_byte = word[7:0];
            2'd1: sel_byte = word[15:8];
            2'd2: sel_byte = word[23:16];
            2'd3: sel_byte = word[31:24];
            default: sel_byte = word[7:0];
        endcase
    end

    assign sel_half = byte_offset[1] ? word[31:16] : word[15:0];

    always_comb begin
        value = 32'd0;
        case (MemSize)
            SIZE_BYTE: value = {{24{MemSigned & sel_byte[7]}}, sel_byte};
            SIZE_HALF: value = {{16{MemSigned & sel_half[15]}}, sel_half};
            SIZE_WORD: value = word;
            default:   value = 32'd0;
        endcase
    end

endmodule

// File: rtl/data_memory.sv
// rtl/data_memory.sv - byte-addressable data memory with alignment checking and fault capture
//
// Purpose : DEPTH_WORDS x 32-bit data memory. Combinational reads, byte-lane
//           stores on the rising edge, misalignment detection and a sticky
//           first-fault address register.
// Ports   : clk        - rising-edge clock
//           reset      - synchronous active-high reset (clears memory and fault)
//           MemRead    - load enable
//           MemWrite   - store enable
//           MemSize    - 00 byte, 01 halfword, 10 word, 11 illegal
//           MemSigned  - sign-extend byte/halfword loads
//           Address    - byte address (upper bits wrap)
//           WriteData  - store data, low bits used for byte/halfword
//           ReadData   - combinational load result
//           AccessErr  - combinational error flag for this access
//           FaultValid - sticky: an access error occurred since reset
//           FaultAddr  - address of the first erroneous access since reset

module data_memory
    import data_memory_pkg::*;
#(
    parameter int DEPTH_WORDS = 64
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  MemSize,
    input  logic        MemSigned,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        AccessErr,
    output logic        FaultValid,
    output logic [31:0] FaultAddr
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    logic [31:0]      mem [DEPTH_WORDS];
    logic [IDX_W-1:0] index;
    logic [1:0]       byte_offset;
    logic [31:0]      cur_word;
    logic [31:0]      aligned;
    logic [3:0]       lane_mask;
    logic [31:0]      store_data;
    logic             do_store;

    // Address bits above the array are deliberately ignored (wrap-around).
    logic unused_addr_high;
    assign unused_addr_high = ^Address[31:IDX_W+2];

    assign index       = Address[IDX_W+1:2];
    assign byte_offset = Address[1:0];
    assign cur_word    = mem[index];

    assign AccessErr = (MemRead | MemWrite) & access_misaligned(MemSize, byte_offset);

    load_align u_load_align (
        .word        (cur_word),
        .byte_offset (byte_offset),
        .MemSize     (MemSize),
        .MemSigned   (MemSigned),
        .value       (aligned)
    );

    // cur_word reflects the array before this edge's store, so a combined
    // read+write returns the pre-store contents.
    assign ReadData = (MemRead && !AccessErr) ? aligned : 32'd0;

    assign lane_mask  = store_lanes(MemSize, byte_offset);
    assign store_data = store_replicate(MemSize, WriteData);
    assign do_store   = MemWrite & ~AccessErr;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int w = 0; w < DEPTH_WORDS; w++) begin
                mem[w] <= 32'd0;
            end
        end else if (do_store) begin
            for (int lane = 0; lane < 4; lane++) begin
                if (lane_mask[lane]) begin
                    mem[index][lane*8 +: 8] <= store_data[lane*8 +: 8];
                end
            end
        end
    end

    // Only the first error after reset is recorded; later ones are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            FaultValid <= 1'b0;
            FaultAddr  <= 32'd0;
        end else if (AccessErr && !FaultValid) begin
            FaultValid <= 1'b1;
            FaultAddr  <= Address;
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// tb/tb_data_memory.sv - scoreboard bench for data_memory

module tb_data_memory;
    import data_memory_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead;
    logic        MemWrite;
    logic [1:0]  MemSize;
    logic        MemSigned;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        AccessErr;
    logic        FaultValid;
    logic [31:0] FaultAddr;

    data_memory #(.DEPTH_WORDS(64)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .MemSize    (MemSize),
        .MemSigned  (MemSigned),
        .Address    (Address),
        .WriteData  (WriteData),
        .ReadData   (ReadData),
        .AccessErr  (AccessErr),
        .FaultValid (FaultValid),
        .FaultAddr  (FaultAddr)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        err;
        logic        fv;
        logic [31:0] fa;
    } exp_t;

    exp_t exp_q[$];
    logic chk = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   pushed = 0;
    int   popped = 0;

    task automatic cmp(input string nm, input string field,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s actual=%h expected=%h", nm, field, act, exp);
        end
    endtask

    // Monitor: samples the combinational outputs mid-cycle, away from the edge.
    always @(negedge clk) begin
        if (chk) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL monitor: output presented with empty scoreboard");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                popped++;
                cmp(e.name, "ReadData",   ReadData,          e.rdata);
                cmp(e.name, "AccessErr",  {31'd0, AccessErr},  {31'd0, e.err});
                cmp(e.name, "FaultValid", {31'd0, FaultValid}, {31'd0, e.fv});
                cmp(e.name, "FaultAddr",  FaultAddr,         e.fa);
            end
        end
    end

    // One bus cycle: drive inputs just after the edge, optionally queue the
    // expected response (faults shown are the state before this cycle's edge).
    task automatic step(input string nm, input logic rst, input logic rd, input logic wr,
                        input logic [1:0] sz, input logic sg, input logic [31:0] ad,
                        input logic [31:0] wd, input logic chk_en,
                        input logic [31:0] e_rd, input logic e_err,
                        input logic e_fv, input logic [31:0] e_fa);
        exp_t e;
        reset = rst; MemRead = rd; MemWrite = wr; MemSize = sz;
        MemSigned = sg; Address = ad; WriteData = wd;
        if (chk_en) begin
            e.name = nm; e.rdata = e_rd; e.err = e_err; e.fv = e_fv; e.fa = e_fa;
            exp_q.push_back(e);
            pushed++;
        end
        chk = chk_en;
        @(posedge clk);
        #1;
        chk = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; MemSize = SIZE_WORD;
        MemSigned = 1'b0; Address = 32'd0; WriteData = 32'd0;
        @(posedge clk);
        #1;
        //     name           rst rd wr size       sg addr          wdata         chk rdata         err fv fa
        step("rst_hold",      1, 1, 0, SIZE_WORD, 0, 32'h10, 32'h0,         1, 32'h0,        0, 0, 32'h0);
        step("st_w_10",       0, 0, 1, SIZE_WORD, 0, 32'h10, 32'hDEADBEEF,  1, 32'h0,        0, 0, 32'h0);
        step("ld_bs_10",      0, 1, 0, SIZE_BYTE, 1, 32'h10, 32'h0,         1, 32'hFFFFFFEF, 0, 0, 32'h0);
        step("ld_bs_11",      0, 1, 0, SIZE_BYTE, 1, 32'h11, 32'h0,         1, 32'hFFFFFFBE, 0, 0, 32'h0);
        step("ld_bs_12",      0, 1, 0, SIZE_BYTE, 1, 32'h12, 32'h0,         1, 32'hFFFFFFAD, 0, 0, 32'h0);
        step("ld_bs_13",      0, 1, 0, SIZE_BYTE, 1, 32'h13, 32'h0,         1, 32'hFFFFFFDE, 0, 0, 32'h0);
        step("ld_bu_13",      0, 1, 0, SIZE_BYTE, 0, 32'h13, 32'h0,         1, 32'h000000DE, 0, 0, 32'h0);
        step("ld_ws_10",      0, 1, 0, SIZE_WORD, 1, 32'h10, 32'h0,         1, 32'hDEADBEEF, 0, 0, 32'h0);
        step("ld_hu_12",      0, 1, 0, SIZE_HALF, 0, 32'h12, 32'h0,         1, 32'h0000DEAD, 0, 0, 32'h0);
        step("st_b_13",       0, 0, 1, SIZE_BYTE, 1, 32'h13, 32'hFFFFFF77,  1, 32'h0,        0, 0, 32'h0);
        step("ld_w_10_lane",  0, 1, 0, SIZE_WORD, 0, 32'h10, 32'h0,         1, 32'h77ADBEEF, 0, 0, 32'h0);
        step("st_w_20",       0, 0, 1, SIZE_WORD, 0, 32'h20, 32'hAAAAAAAA,  1, 32'h0,        0, 0, 32'h0);
        step("st_h_22",       0, 0, 1, SIZE_HALF, 0, 32'h22, 32'hFFFF1234,  1, 32'h0,        0, 0, 32'h0);
        step("ld_w_20",       0, 1, 0, SIZE_WORD, 0, 32'h20, 32'h0,         1, 32'h1234AAAA, 0, 0, 32'h0);
        step("ld_hs_20",      0, 1, 0, SIZE_HALF, 1, 32'h20, 32'h0,         1, 32'hFFFFAAAA, 0, 0, 32'h0);
        step("ld_hu_22",      0, 1, 0, SIZE_HALF, 0, 32'h22, 32'h0,         1, 32'h00001234, 0, 0, 32'h0);
        step("idle_no_read",  0, 0, 0, SIZE_WORD, 0, 32'h20, 32'h0,         1, 32'h0,        0, 0, 32'h0);
        step("st_w_06_err",   0, 0, 1, SIZE_WORD, 0, 32'h06, 32'hCAFEF00D,  1, 32'h0,        1, 0, 32'h0);
        step("ld_w_04_kept",  0, 1, 0, SIZE_WORD, 0, 32'h04, 32'h0,         1, 32'h0,        0, 1, 32'h06);
        step("st_h_09_err",   0, 0, 1, SIZE_HALF, 0, 32'h09, 32'h1111,      1, 32'h0,        1, 1, 32'h06);
        step("ld_w_08_kept",  0, 1, 0, SIZE_WORD, 0, 32'h08, 32'h0,         1, 32'h0,        0, 1, 32'h06);
        step("ld_illegal",    0, 1, 0, SIZE_ILLEGAL, 0, 32'h0C, 32'h0,      1, 32'h0,        1, 1, 32'h06);
        step("ld_h_11_err",   0, 1, 0, SIZE_HALF, 0, 32'h11, 32'h0,         1, 32'h0,        1, 1, 32'h06);
        step("idle_err_gate", 0, 0, 0, SIZE_ILLEGAL, 0, 32'h07, 32'h0,      1, 32'h0,        0, 1, 32'h06);
        step("st_w_104_wrap", 0, 0, 1, SIZE_WORD, 0, 32'h104, 32'h11111111, 1, 32'h0,        0, 1, 32'h06);
        step("ld_w_004_wrap", 0, 1, 0, SIZE_WORD, 0, 32'h004, 32'h0,        1, 32'h11111111, 0, 1, 32'h06);
        step("rw_b_30",       0, 1, 1, SIZE_BYTE, 0, 32'h30, 32'h00000055,  1, 32'h0,        0, 1, 32'h06);
        step("ld_bu_30",      0, 1, 0, SIZE_BYTE, 0, 32'h30, 32'h0,         1, 32'h00000055, 0, 1, 32'h06);
        step("ld_w_30",       0, 1, 0, SIZE_WORD, 0, 32'h30, 32'h0,         1, 32'h00000055, 0, 1, 32'h06);
        step("rst_st_40",     1, 0, 1, SIZE_WORD, 0, 32'h40, 32'h12345678,  1, 32'h0,        0, 1, 32'h06);
        step("ld_w_40_rst",   0, 1, 0, SIZE_WORD, 0, 32'h40, 32'h0,         1, 32'h0,        0, 0, 32'h0);
        step("ld_w_10_rst",   0, 1, 0, SIZE_WORD, 0, 32'h10, 32'h0,         1, 32'h0,        0, 0, 32'h0);
        step("rst_err_42",    1, 0, 1, SIZE_WORD, 0, 32'h42, 32'h12345678,  1, 32'h0,        1, 0, 32'h0);
        step("ld_w_40_nocap", 0, 1, 0, SIZE_WORD, 0, 32'h40, 32'h0,         1, 32'h0,        0, 0, 32'h0);
        step("ld_h_23_err",   0, 1, 0, SIZE_HALF, 0, 32'h23, 32'h0,         1, 32'h0,        1, 0, 32'h0);
        step("fault_23",      0, 0, 0, SIZE_WORD, 0, 32'h0,  32'h0,         1, 32'h0,        0, 1, 32'h23);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || popped != pushed) begin
            errors++;
            $display("FAIL drain: popped=%0d pushed=%0d left=%0d", popped, pushed, exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 Parameter DEPTH_WORDS, default 64, SHALL set the number of 32-bit words; it SHALL be a power of two, minimum 4.
REQ-002 The block SHALL use one clock and a synchronous, active-high reset.
REQ-003 clk  input  1  rising-edge clock; all state changes on this edge.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 MemRead  input  1  load enable.
REQ-006 MemWrite  input  1  store enable.
REQ-007 MemSize  input  2  access size: 00 byte, 01 halfword, 10 word, 11 illegal.
REQ-008 MemSigned  input  1  loads only: 1 sign-extends, 0 zero-extends byte/halfword.
REQ-009 Address  input  32  byte address, driven by the ALU result.
REQ-010 WriteData  input  32  store data (rt); byte/halfword taken from low bits.
REQ-011 ReadData  output  32  load result, combinational.
REQ-012 AccessErr  output  1  combinational error flag for the current access.
REQ-013 FaultValid  output  1  sticky flag: an access error has occurred since reset.
REQ-014 FaultAddr  output  32  Address of the first erroneous access since reset.

Function
REQ-015 Word index SHALL be Address[log2(DEPTH_WORDS)+1:2]; higher address bits SHALL be ignored (modulo wrap-around).
REQ-016 Byte order SHALL be little-endian: Address[1:0]=0 selects bits 7:0; halfword at Address[1]=0 selects bits 15:0.
REQ-017 AccessErr SHALL be 1 when (MemRead|MemWrite)=1 and any of: MemSize=11, halfword with Address[0]=1, word with Address[1:0]!=00; otherwise 0.
REQ-018 Reads SHALL be combinational from the current array contents: zero added latency, result valid in the same cycle.
REQ-019 ReadData SHALL be 0 when MemRead=0 or AccessErr=1.
REQ-020 A store SHALL update only the addressed byte lanes at the rising edge; other lanes SHALL hold their value.
REQ-021 A store with AccessErr=1 SHALL NOT modify memory.
REQ-022 MemRead=1 and MemWrite=1 together SHALL perform the store and return pre-store contents on ReadData in that cycle.
REQ-023 On the first edge where AccessErr=1 and FaultValid=0, FaultValid SHALL be set and FaultAddr SHALL capture Address.
REQ-024 While FaultValid=1, later errors SHALL NOT change FaultAddr.
REQ-025 MemSigned SHALL be ignored for word loads and for stores.

Reset
REQ-026 On reset=1 at a rising edge, all memory words SHALL become 0, FaultValid SHALL become 0 and FaultAddr SHALL become 0.
REQ-027 Reset SHALL take priority over a simultaneous store or fault capture, and no store or capture issued in that cycle SHALL take effect.
REQ-028 Reset asserted during an access sequence SHALL abort it without partial writes; the next access after reset deassertion SHALL see an all-zero memory.

Structure
REQ-029 The MemSize encodings (SIZE_BYTE, SIZE_HALF, SIZE_WORD) SHALL live in the shared include with the ALU control encodings.
REQ-030 Load lane selection and extension SHALL be one combinational sub-module, load_align (inputs: word, Address[1:0], MemSize, MemSigned; output: 32-bit value).
REQ-031 Store lane merge and the fault register SHALL stay in data_memory.

Verification
REQ-032 Store word 0xDEADBEEF at address 0x10, then load bytes 0x10..0x13 signed -> 0xFFFFFFEF, 0xFFFFFFBE, 0xFFFFFFAD, 0xFFFFFFDE; unsigned byte at 0x13 -> 0x000000DE.
REQ-033 Store halfword 0x1234 at 0x22 over word 0xAAAAAAAA -> word load at 0x20 returns 0x1234AAAA; signed halfword load at 0x20 -> 0xFFFFAAAA.
REQ-034 Word store at 0x06 -> AccessErr=1, memory unchanged, FaultValid=1, FaultAddr=0x06; a following halfword store at 0x09 -> FaultAddr stays 0x06.
REQ-035 With DEPTH_WORDS=64, store 0x11111111 at 0x104 -> word load at 0x004 returns 0x11111111 (wrap-around).
REQ-036 Read and write of 0x55 byte at 0x30 (old 0x00) in the same cycle -> ReadData 0x0 that cycle, 0x55 next cycle.
REQ-037 Store to 0x40 with reset=1 in the same cycle -> word load at 0x40 returns 0, FaultValid=0.
